// File: rtl/dta_egr_snd_req_scheduler.sv
// Egress send request scheduler: round-robin arbitration across N_CH frame sources,
// burst splitting up to MAX_BURST beats, one outstanding req/resp/data at a time.
module dta_egr_snd_req_scheduler #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_BURST = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [N_CH-1:0]    cmd_valid,
  input  logic [16*N_CH-1:0] cmd_length,
  output logic [N_CH-1:0]    cmd_ready,
  output logic               req_tvalid,
  input  logic               req_tready,
  output logic [63:0]        req_tdata,
  input  logic               resp_tvalid,
  output logic               resp_tready,
  input  logic [63:0]        resp_tdata,
  input  logic               data_tvalid,
  input  logic               data_tready,
  output logic               busy,
  output logic [1:0]         sched_error
);

  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SW = PW + 1;
  localparam logic [15:0] MB = 16'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, ARB, REQ, RESP, DATA, HALT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, sel_q, sel_d, sel_inc;
  logic [15:0]       rem_q [N_CH];
  logic [15:0]       rem_d [N_CH];
  logic [N_CH-1:0]   act_q, act_d, first_q, first_d, cmd_ready_q, cmd_ready_d;
  logic [15:0]       dcnt_q, dcnt_d, blen_q, blen_d;
  logic [63:0]       req_data_q, req_data_d;
  logic              req_valid_q, resp_ready_q, busy_q;
  logic [1:0]        err_q, err_d;

  logic              found;
  logic [PW-1:0]     pick, idx;
  logic [SW-1:0]     sum;
  logic [15:0]       rem_pick, blen_pick;
  logic [15:0]       resp_ch, resp_len;
  logic              unused_resp_bits;

  assign resp_ch          = resp_tdata[15:0];
  assign resp_len         = resp_tdata[63:48];
  assign unused_resp_bits = ^resp_tdata[47:16];
  assign sel_inc          = (sel_q == PW'(N_CH - 1)) ? '0 : sel_q + 1'b1;

  // Round-robin search: first active channel at or after ptr, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(N_CH)) sum = sum - SW'(N_CH);
      idx = sum[PW-1:0];
      if (!found && act_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    rem_pick  = rem_q[pick];
    blen_pick = (rem_pick > MB) ? MB : rem_pick;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    act_d       = act_q;
    first_d     = first_q;
    rem_d       = rem_q;
    dcnt_d      = dcnt_q;
    blen_d      = blen_q;
    req_data_d  = req_data_q;
    cmd_ready_d = '0;
    err_d       = err_q;
    case (state_q)
      IDLE: if (|act_q) state_d = ARB;
      ARB: begin
        if (found) begin
          sel_d      = pick;
          blen_d     = blen_pick;
          req_data_d = {blen_pick, 30'd0, (rem_pick <= MB), first_q[pick], 16'(pick)};
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: if (req_tready) state_d = RESP;
      RESP: begin
        if (resp_tvalid) begin
          if (resp_ch != 16'(sel_q) || resp_len > blen_q) begin
            err_d[0] = err_q[0] | (resp_ch != 16'(sel_q));
            err_d[1] = err_q[1] | (resp_len > blen_q);
            state_d  = HALT;
          end else if (resp_len == 16'd0) begin
            ptr_d   = sel_inc;
            state_d = (|act_q) ? ARB : IDLE;
          end else begin
            rem_d[sel_q]   = rem_q[sel_q] - resp_len;
            first_d[sel_q] = 1'b0;
            dcnt_d         = resp_len;
            state_d        = DATA;
          end
        end
      end
      DATA: begin
        if (data_tvalid && data_tready) begin
          dcnt_d = dcnt_q - 16'd1;
          if (dcnt_q == 16'd1) begin
            if (rem_q[sel_q] == 16'd0) begin
              cmd_ready_d[sel_q] = 1'b1;
              act_d[sel_q]       = 1'b0;
            end
            ptr_d   = sel_inc;
            state_d = (|act_d) ? ARB : IDLE;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // Frame latch runs in every state; it never collides with a clear since it needs act low.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cmd_valid[i] && !act_q[i]) begin
        act_d[i]   = 1'b1;
        rem_d[i]   = cmd_length[16*i +: 16];
        first_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      act_q        <= '0;
      first_q      <= '0;
      for (int unsigned i = 0; i < N_CH; i++) rem_q[i] <= '0;
      dcnt_q       <= '0;
      blen_q       <= '0;
      req_data_q   <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      cmd_ready_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      act_q        <= act_d;
      first_q      <= first_d;
      rem_q        <= rem_d;
      dcnt_q       <= dcnt_d;
      blen_q       <= blen_d;
      req_data_q   <= req_data_d;
      req_valid_q  <= (state_d == REQ);
      resp_ready_q <= (state_d == RESP);
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= (state_q != IDLE);
      err_q        <= err_d;
    end
  end

  assign req_tvalid  = req_valid_q;
  assign req_tdata   = req_data_q;
  assign resp_tready = resp_ready_q;
  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign sched_error = err_q;

endmodule
